// File: rtl/traffic_lamp_sequencer_pkg.sv
// Shared types for the traffic lamp sequencer: FSM states and per-direction lamp vectors.
package traffic_pkg;

  typedef enum logic [2:0] {
    IDLE_RED,
    NS_GO,
    NS_AMBER,
    NS_CLEAR,
    EW_GO,
    EW_AMBER,
    EW_CLEAR,
    FAULT
  } traffic_state_t;

  typedef struct packed {
    logic red;
    logic amber;
    logic green;
  } lamp_t;

  localparam lamp_t LAMP_RED   = 3'b100;
  localparam lamp_t LAMP_AMBER = 3'b010;
  localparam lamp_t LAMP_GREEN = 3'b001;
  localparam lamp_t LAMP_OFF   = 3'b000;

endpackage

// File: rtl/traffic_lamp_sequencer_if.sv
// Request/lamp bundle between the upstream controller (master) and the lamp sequencer (slave).
// Requests are level signals sampled every rising clk edge; lamps and status are registered Moore outputs.
interface traffic_lamp_sequencer_if;
  logic ns_green_req;
  logic ew_green_req;
  logic ns_red;
  logic ns_amber;
  logic ns_green;
  logic ew_red;
  logic ew_amber;
  logic ew_green;
  logic busy;
  logic fault;

  modport master (
    output ns_green_req, ew_green_req,
    input  ns_red, ns_amber, ns_green, ew_red, ew_amber, ew_green, busy, fault
  );

  modport slave (
    input  ns_green_req, ew_green_req,
    output ns_red, ns_amber, ns_green, ew_red, ew_amber, ew_green, busy, fault
  );
endinterface

// File: rtl/traffic_lamp_sequencer_phase_timer.sv
// Down-counter shared by the green, amber, clear and flash phases; a load wins over a decrement.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/traffic_lamp_sequencer.sv
// Lamp sequencer: turns per-direction green requests into lamp drive with min-green,
// amber and all-red clearance timing, plus a sticky flashing-red fault on conflicting requests.
module traffic_lamp_sequencer
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN     = 4,
  parameter int AMBER_CYCLES  = 3,
  parameter int ALLRED_CYCLES = 2,
  parameter int FLASH_CYCLES  = 2,
  parameter int CNT_W         = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  traffic_lamp_sequencer_if.slave  bus,
  output traffic_state_t           dbg_state
);

  localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] AMBER_LOAD  = CNT_W'(AMBER_CYCLES - 1);
  localparam logic [CNT_W-1:0] ALLRED_LOAD = CNT_W'(ALLRED_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLASH_LOAD  = CNT_W'(FLASH_CYCLES - 1);

  traffic_state_t   state_q, state_d;
  logic             flash_q, flash_d;
  lamp_t            ns_q, ns_d, ew_q, ew_d;
  logic             busy_q, busy_d, fault_q, fault_d;
  logic             load;
  logic [CNT_W-1:0] load_value;
  logic             done;
  logic             ns_req, ew_req;

  assign ns_req = bus.ns_green_req;
  assign ew_req = bus.ew_green_req;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_value (load_value),
    .done       (done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE_RED;
      flash_q <= 1'b0;
      ns_q    <= LAMP_RED;
      ew_q    <= LAMP_RED;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      flash_q <= flash_d;
      ns_q    <= ns_d;
      ew_q    <= ew_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    flash_d    = flash_q;
    load       = 1'b0;
    load_value = '0;
    if (state_q != FAULT && ns_req && ew_req) begin
      // Conflicting requests: reds start lit and the timer paces the flash.
      state_d    = FAULT;
      flash_d    = 1'b1;
      load       = 1'b1;
      load_value = FLASH_LOAD;
    end else begin
      case (state_q)
        IDLE_RED: begin
          if (ns_req) begin
            state_d = NS_GO; load = 1'b1; load_value = GREEN_LOAD;
          end else if (ew_req) begin
            state_d = EW_GO; load = 1'b1; load_value = GREEN_LOAD;
          end
        end
        NS_GO: if (done && !ns_req) begin
          state_d = NS_AMBER; load = 1'b1; load_value = AMBER_LOAD;
        end
        NS_AMBER: if (done) begin
          state_d = NS_CLEAR; load = 1'b1; load_value = ALLRED_LOAD;
        end
        NS_CLEAR: if (done) begin
          // Opposite direction gets priority so a waiting request is not starved.
          if (ew_req) begin
            state_d = EW_GO; load = 1'b1; load_value = GREEN_LOAD;
          end else if (ns_req) begin
            state_d = NS_GO; load = 1'b1; load_value = GREEN_LOAD;
          end else begin
            state_d = IDLE_RED;
          end
        end
        EW_GO: if (done && !ew_req) begin
          state_d = EW_AMBER; load = 1'b1; load_value = AMBER_LOAD;
        end
        EW_AMBER: if (done) begin
          state_d = EW_CLEAR; load = 1'b1; load_value = ALLRED_LOAD;
        end
        EW_CLEAR: if (done) begin
          if (ns_req) begin
            state_d = NS_GO; load = 1'b1; load_value = GREEN_LOAD;
          end else if (ew_req) begin
            state_d = EW_GO; load = 1'b1; load_value = GREEN_LOAD;
          end else begin
            state_d = IDLE_RED;
          end
        end
        FAULT: if (done) begin
          flash_d = ~flash_q; load = 1'b1; load_value = FLASH_LOAD;
        end
        default: state_d = FAULT;
      endcase
    end
  end

  // Lamps are decoded from the next state so they register in step with the state.
  always_comb begin
    ns_d    = LAMP_RED;
    ew_d    = LAMP_RED;
    busy_d  = 1'b0;
    fault_d = 1'b0;
    case (state_d)
      NS_GO:    ns_d = LAMP_GREEN;
      NS_AMBER: begin ns_d = LAMP_AMBER; busy_d = 1'b1; end
      NS_CLEAR: busy_d = 1'b1;
      EW_GO:    ew_d = LAMP_GREEN;
      EW_AMBER: begin ew_d = LAMP_AMBER; busy_d = 1'b1; end
      EW_CLEAR: busy_d = 1'b1;
      FAULT: begin
        ns_d    = flash_d ? LAMP_RED : LAMP_OFF;
        ew_d    = flash_d ? LAMP_RED : LAMP_OFF;
        fault_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.ns_red   = ns_q.red;
  assign bus.ns_amber = ns_q.amber;
  assign bus.ns_green = ns_q.green;
  assign bus.ew_red   = ew_q.red;
  assign bus.ew_amber = ew_q.amber;
  assign bus.ew_green = ew_q.green;
  assign bus.busy     = busy_q;
  assign bus.fault    = fault_q;
  assign dbg_state    = state_q;

endmodule
